phased_transform_buffer: RTL and testbench

- Parametrised sample buffer. Accepts DATA_W-bit samples over a valid/ready handshake and transforms each one according to a phase taken from a running accept counter.
- Transformed samples go into a DEPTH-entry circular register array. An independent registered read port reads the array.
- A clear command runs a sequenced zero-fill of the array.
- Used as a stimulus/transform block in the grammar and concolic test designs.

---
 rtl/phased_transform_buffer_if.sv | 38 +++
 rtl/phased_transform_buffer.sv | 221 ++++++++++++++++++++++
 tb/tb_phased_transform_buffer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/phased_transform_buffer_if.sv
// Bundle of handshake, clear, read-port and status signals for
// phased_transform_buffer.
//   master : drives samples, clear and read requests; observes the status outputs
//   slave  : the buffer itself
// Signals:
//   in_valid/in_ready/in_data : sample handshake (in_ready is combinational)
//   clear                     : single-cycle zero-fill request
//   rd_en/rd_addr             : read request and index
//   rd_data/rd_valid          : registered read data and one-cycle valid pulse
//   phase                     : transform the next accepted sample will receive
//   busy                      : zero-fill in progress
interface phased_transform_buffer_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    localparam int AW = $clog2(DEPTH);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              clear;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [1:0]        phase;
    logic              busy;

    modport master (
        output in_valid, in_data, clear, rd_en, rd_addr,
        input  in_ready, rd_data, rd_valid, phase, busy
    );

    modport slave (
        input  in_valid, in_data, clear, rd_en, rd_addr,
        output in_ready, rd_data, rd_valid, phase, busy
    );
endinterface

// File: rtl/phased_transform_buffer.sv
// Phased transform sample buffer.
// Each accepted sample is transformed according to a phase decoded from a
// running accept counter (MOD / DIV2 / SHR / ZERO) and written into a DEPTH-entry
// circular register array two edges after acceptance. A clear request runs a
// DEPTH-cycle sequenced zero-fill. An independent registered read port reads the
// array in any state.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-low reset
//   bus_if : phased_transform_buffer_if.slave (handshake, clear, read port, status)
//
// FSM states:
//   state    | meaning
//   ST_RUN   | normal operation, samples accepted when offered and no clear
//   ST_CLEAR | zero-fill of entries 0..DEPTH-1, one per cycle, input stalled
module phased_transform_buffer #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 8,
    parameter int MOD_VAL   = 5,
    parameter int SHIFT_AMT = 2,
    parameter int TH_DIV    = 128,
    parameter int TH_SHIFT  = 192
) (
    input  logic                     clk,
    input  logic                     reset,
    phased_transform_buffer_if.slave bus_if
);
    localparam int AW = $clog2(DEPTH);

    // Thresholds may equal 2^CNT_W, so compare one bit wider than the counter.
    localparam logic [CNT_W:0]    TH_DIV_W   = (CNT_W+1)'(TH_DIV);
    localparam logic [CNT_W:0]    TH_SHIFT_W = (CNT_W+1)'(TH_SHIFT);
    localparam logic [DATA_W-1:0] MOD_W      = DATA_W'(MOD_VAL);
    localparam logic [AW-1:0]     LAST_IDX   = AW'(DEPTH-1);

    typedef enum logic {ST_RUN, ST_CLEAR} state_e;
    typedef enum logic [1:0] {PH_MOD, PH_DIV2, PH_SHR, PH_ZERO} phase_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     clr_idx_q, clr_idx_d;
    logic              stage_valid_q, stage_valid_d;
    logic [DATA_W-1:0] stage_data_q, stage_data_d;
    phase_e            stage_phase_q, stage_phase_d;
    logic [AW-1:0]     stage_ptr_q, stage_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    logic              in_ready;
    logic              busy;
    logic              clr_start;
    logic              accept;
    phase_e            phase_cur;
    logic [DATA_W-1:0] xform_data;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (bus_if.clear) state_d = ST_CLEAR;
            ST_CLEAR: if (clr_idx_q == LAST_IDX) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // FSM: outputs. Clear takes priority over a simultaneously offered sample.
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        clr_start = 1'b0;
        case (state_q)
            ST_RUN: begin
                in_ready  = !bus_if.clear;
                clr_start = bus_if.clear;
            end
            ST_CLEAR: begin
                busy = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    assign accept = bus_if.in_valid && in_ready;

    // ------------------------------------------------------------------
    // Phase decode of the current (pre-increment) accept count
    // ------------------------------------------------------------------
    always_comb begin
        if (cnt_q == '0) begin
            phase_cur = PH_MOD;
        end else if ({1'b0, cnt_q} < TH_DIV_W) begin
            phase_cur = PH_DIV2;
        end else if ({1'b0, cnt_q} < TH_SHIFT_W) begin
            phase_cur = PH_SHR;
        end else begin
            phase_cur = PH_ZERO;
        end
    end

    // ------------------------------------------------------------------
    // Counter, write pointer, clear index and stage next-state
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d         = cnt_q;
        wr_ptr_d      = wr_ptr_q;
        stage_valid_d = accept;
        stage_data_d  = stage_data_q;
        stage_phase_d = stage_phase_q;
        stage_ptr_d   = stage_ptr_q;
        clr_idx_d     = busy ? clr_idx_q + AW'(1) : '0;

        if (clr_start) begin
            cnt_d    = '0;
            wr_ptr_d = '0;
        end else if (accept) begin
            cnt_d         = cnt_q + CNT_W'(1);
            wr_ptr_d      = wr_ptr_q + AW'(1);
            stage_data_d  = bus_if.in_data;
            stage_phase_d = phase_cur;
            stage_ptr_d   = wr_ptr_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q         <= '0;
            wr_ptr_q      <= '0;
            clr_idx_q     <= '0;
            stage_valid_q <= 1'b0;
            stage_data_q  <= '0;
            stage_phase_q <= PH_MOD;
            stage_ptr_q   <= '0;
        end else begin
            cnt_q         <= cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            clr_idx_q     <= clr_idx_d;
            stage_valid_q <= stage_valid_d;
            stage_data_q  <= stage_data_d;
            stage_phase_q <= stage_phase_d;
            stage_ptr_q   <= stage_ptr_d;
        end
    end

    // ------------------------------------------------------------------
    // Transform and array write port
    // ------------------------------------------------------------------
    always_comb begin
        case (stage_phase_q)
            PH_MOD:  xform_data = stage_data_q % MOD_W;
            PH_DIV2: xform_data = stage_data_q >> 1;
            PH_SHR:  xform_data = stage_data_q >> SHIFT_AMT;
            default: xform_data = '0;
        endcase
    end

    // A stage write and a clear write never coincide: the last possible stage
    // write lands on the edge that enters CLEAR, and CLEAR blocks new accepts.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (stage_valid_q) begin
            wr_en   = 1'b1;
            wr_addr = stage_ptr_q;
            wr_data = xform_data;
        end else if (busy) begin
            wr_en   = 1'b1;
            wr_addr = clr_idx_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Registered read port; same-edge write returns the pre-write value
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus_if.rd_en;
            if (bus_if.rd_en) begin
                rd_data_q <= mem_q[bus_if.rd_addr];
            end
        end
    end

    assign bus_if.in_ready = in_ready;
    assign bus_if.busy     = busy;
    assign bus_if.phase    = phase_cur;
    assign bus_if.rd_data  = rd_data_q;
    assign bus_if.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_phased_transform_buffer.sv
// Directed self-checking bench for phased_transform_buffer (default parameters).
module tb_phased_transform_buffer;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cnt_m  = 0;

    always #5 clk = ~clk;

    phased_transform_buffer_if bus_if ();

    phased_transform_buffer dut (
        .clk    (clk),
        .reset  (reset),
        .bus_if (bus_if)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One-cycle accept; consecutive calls give back-to-back accepts.
    task automatic push(input logic [31:0] d);
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = d;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        cnt_m = (cnt_m + 1) % 256;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input int a, input logic [31:0] exp, input string tag);
        bus_if.rd_en   = 1'b1;
        bus_if.rd_addr = 2'(a);
        @(posedge clk);
        #1;
        bus_if.rd_en = 1'b0;
        check(tag, bus_if.rd_data, exp);
        check({tag, "_valid"}, 32'(bus_if.rd_valid), 32'd1);
    endtask

    initial begin
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = '0;
        bus_if.clear    = 1'b0;
        bus_if.rd_en    = 1'b0;
        bus_if.rd_addr  = '0;

        // Reset state
        #12;
        check("rst_rd_valid", 32'(bus_if.rd_valid), 32'd0);
        check("rst_rd_data",  bus_if.rd_data,       32'd0);
        check("rst_busy",     32'(bus_if.busy),     32'd0);
        check("rst_phase",    32'(bus_if.phase),    32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("run_in_ready", 32'(bus_if.in_ready), 32'd1);

        // Four back-to-back accepts: MOD, DIV2, DIV2, DIV2
        push(23);
        push(100);
        push(7);
        push(9);
        check("phase_cnt4", 32'(bus_if.phase), 32'd1);
        idle(1);
        bus_if.rd_en   = 1'b1;
        bus_if.rd_addr = 2'd0;
        @(posedge clk);
        #1;
        check("rd0",       bus_if.rd_data,       32'd3);
        check("rd0_valid", 32'(bus_if.rd_valid), 32'd1);
        bus_if.rd_addr = 2'd1;
        @(posedge clk);
        #1;
        bus_if.rd_en = 1'b0;
        check("rd1",       bus_if.rd_data,       32'd50);
        check("rd1_valid", 32'(bus_if.rd_valid), 32'd1);
        @(posedge clk);
        #1;
        check("rd_valid_drop", 32'(bus_if.rd_valid), 32'd0);
        check("rd_data_hold",  bus_if.rd_data,       32'd50);
        rd(2, 32'd3, "rd2");
        rd(3, 32'd4, "rd3");

        // Wrap of write pointer
        push(40);
        check("phase_cnt5", 32'(bus_if.phase), 32'd1);
        idle(1);
        rd(0, 32'd20, "wrap_e0");

        // SHR phase at cnt=128
        while (cnt_m != 128) push(255);
        check("phase_cnt128", 32'(bus_if.phase), 32'd2);
        push(400);
        idle(1);
        rd(0, 32'd100, "shr_e0");

        // ZERO phase at cnt=192 (entry 0 previously held 255>>2=63)
        while (cnt_m != 192) push(255);
        check("phase_cnt192", 32'(bus_if.phase), 32'd3);
        push(400);
        idle(1);
        rd(0, 32'd0, "zero_e0");

        // Counter wrap back to MOD
        while (cnt_m != 0) push(255);
        check("phase_wrap", 32'(bus_if.phase), 32'd0);
        push(23);
        idle(1);
        rd(0, 32'd3, "wrapmod_e0");

        // Fill entries 1..3 with 50, then clear with a competing sample
        push(100);
        push(100);
        push(100);
        bus_if.clear    = 1'b1;
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = 77;
        #1;
        check("clr_in_ready_comb", 32'(bus_if.in_ready), 32'd0);
        @(posedge clk);
        #1;
        bus_if.clear    = 1'b0;
        bus_if.in_valid = 1'b0;
        cnt_m = 0;
        for (int i = 0; i < 4; i++) begin
            check("clr_busy",     32'(bus_if.busy),     32'd1);
            check("clr_in_ready", 32'(bus_if.in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        check("post_clr_busy",     32'(bus_if.busy),     32'd0);
        check("post_clr_in_ready", 32'(bus_if.in_ready), 32'd1);
        check("post_clr_phase",    32'(bus_if.phase),    32'd0);
        rd(0, 32'd0, "clr_e0");
        rd(1, 32'd0, "clr_e1");
        rd(2, 32'd0, "clr_e2");
        rd(3, 32'd0, "clr_e3");
        push(12);
        idle(1);
        rd(0, 32'd2, "post_clr_e0");

        // Read/write collision on entry 1: old 4, new 50
        push(9);
        push(8);
        push(8);
        push(8);
        push(100);
        bus_if.rd_en   = 1'b1;
        bus_if.rd_addr = 2'd1;
        @(posedge clk);
        #1;
        check("collide_old", bus_if.rd_data, 32'd4);
        @(posedge clk);
        #1;
        bus_if.rd_en = 1'b0;
        check("collide_new",   bus_if.rd_data,       32'd50);
        check("collide_valid", 32'(bus_if.rd_valid), 32'd1);

        // Asynchronous reset mid-stream
        #2;
        reset = 1'b0;
        #1;
        check("arst_rd_valid", 32'(bus_if.rd_valid), 32'd0);
        check("arst_rd_data",  bus_if.rd_data,       32'd0);
        check("arst_phase",    32'(bus_if.phase),    32'd0);
        check("arst_busy",     32'(bus_if.busy),     32'd0);
        #2;
        reset = 1'b1;
        cnt_m = 0;
        @(posedge clk);
        #1;
        check("rel_phase", 32'(bus_if.phase), 32'd0);
        rd(0, 32'd0, "rel_e0");
        rd(1, 32'd0, "rel_e1");
        rd(2, 32'd0, "rel_e2");
        rd(3, 32'd0, "rel_e3");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
